// File: rtl/move_acceptance.sv
// Metropolis-style move acceptance: compares unsatisfied-clause counts and draws against an 8-bit LFSR.
// Optional MOVE_ACCEPTANCE_STATS_EN adds saturating accept/reject counters.
module move_acceptance #(
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
    parameter int CLAUSE_WEIGHT_SHIFT            = 1
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic [7:0]                            in_seed,
    input  logic                                  in_enable,
    input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_u,
    input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_v,
    output logic                                  out_busy,
    output logic                                  out_done,
`ifdef MOVE_ACCEPTANCE_STATS_EN
    output logic [15:0]                           out_accept_count,
    output logic [15:0]                           out_reject_count,
`endif
    output logic                                  out_p
);

    localparam int W  = MAX_BIT_WIDTH_OF_CLAUSES_INDEX + 1;
    localparam int SW = W + 32;

    typedef enum logic [1:0] {IDLE, COMPARE, DRAW, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      lfsr;
    logic [7:0]      lfsr_step;
    logic            seeded;
    logic [W-1:0]    u_p0, v_p0;
    logic            accept_p1;
    logic [SW-1:0]   s_p1;
    logic            draw_accept;

    // An all-zero seed would lock the LFSR, so it is replaced.
    function automatic logic [7:0] seed_fix(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'hA5 : seed;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        out_busy   = 1'b1;
        out_done   = 1'b0;
        case (state)
            IDLE: begin
                out_busy = 1'b0;
                if (in_enable) state_next = COMPARE;
            end
            COMPARE: state_next = DRAW;
            DRAW:    state_next = DONE;
            DONE: begin
                out_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_comb begin
        draw_accept = 1'b1;
        if (!accept_p1) begin
            if (s_p1 >= SW'(8)) draw_accept = 1'b0;
            else draw_accept = ({1'b0, lfsr_step} < (9'd1 << (4'd8 - s_p1[3:0])));
        end
    end

    // Stage p0: operands captured on the edge leaving IDLE
    always_ff @(posedge in_clock) begin
        if (state == IDLE && in_enable) begin
            u_p0 <= in_u;
            v_p0 <= in_v;
        end
    end

    // Stage p1: comparison and scaled difference
    always_ff @(posedge in_clock) begin
        if (state == COMPARE) begin
            accept_p1 <= (v_p0 <= u_p0);
            s_p1      <= SW'(v_p0 - u_p0) * SW'(CLAUSE_WEIGHT_SHIFT);
        end
    end

    // Stage p2: LFSR draw and registered decision
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            lfsr   <= 8'h00;
            seeded <= 1'b0;
            out_p  <= 1'b0;
        end else begin
            if (state == COMPARE && !seeded) begin
                lfsr   <= seed_fix(in_seed);
                seeded <= 1'b1;
            end
            if (state == DRAW) begin
                lfsr  <= lfsr_step;
                out_p <= draw_accept;
            end
        end
    end

`ifdef MOVE_ACCEPTANCE_STATS_EN
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            out_accept_count <= 16'd0;
            out_reject_count <= 16'd0;
        end else if (state == DONE) begin
            if (out_p) out_accept_count <= sat_inc(out_accept_count);
            else       out_reject_count <= sat_inc(out_reject_count);
        end
    end
`endif

endmodule

// File: doc/move_acceptance.md
MOVE_ACCEPTANCE -- requirements
Module: move_acceptance

Interface
REQ-001 SHALL have parameter MAX_BIT_WIDTH_OF_CLAUSES_INDEX, default 3, the clause-index width; clause counts are MAX_BIT_WIDTH_OF_CLAUSES_INDEX+1 bits wide (W).
REQ-002 SHALL have parameter CLAUSE_WEIGHT_SHIFT, default 1, the probability halvings per extra unsatisfied clause.
REQ-003 SHALL have one clock; reset SHALL be asynchronous and active-low; ports are named in_clock and in_reset.
REQ-004 in_clock  input  1  rising-edge clock.
REQ-005 in_reset  input  1  asynchronous active-low reset.
REQ-006 in_seed  input  8  LFSR seed, loaded on the first accepted start after reset.
REQ-007 in_enable  input  1  start request; sampled only in IDLE.
REQ-008 in_u  input  W  unsatisfied clause count before the move.
REQ-009 in_v  input  W  unsatisfied clause count after the proposed move.
REQ-010 out_busy  output  1  high in every state except IDLE.
REQ-011 out_done  output  1  one-cycle pulse; out_p is valid in that cycle.
REQ-012 out_p  output  1  1 = accept the proposed move; held until the next out_done.

Function
REQ-013 SHALL implement states IDLE, COMPARE, DRAW and DONE: IDLE->COMPARE on in_enable=1; COMPARE->DRAW; DRAW->DONE; DONE->IDLE, all unconditional.
REQ-014 SHALL capture in_u and in_v on the clock edge that leaves IDLE; later input changes SHALL NOT affect the decision.
REQ-015 SHALL assert out_done exactly 3 clock edges after the edge that samples in_enable, with fixed latency regardless of the operand values.
REQ-016 SHALL ignore in_enable outside IDLE; a start re-sampled in the DONE->IDLE cycle SHALL NOT be lost, because IDLE samples it on the next edge.
REQ-017 In COMPARE: if v<=u, decision = accept; otherwise d = v-u and s = d*CLAUSE_WEIGHT_SHIFT, computed at full width with no overflow.
REQ-018 SHALL implement an 8-bit Fibonacci LFSR with taps 8,6,5,4: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-019 The LFSR SHALL advance exactly once per DRAW state and SHALL hold in all other states.
REQ-020 SHALL seed the LFSR from in_seed in the COMPARE of the first start after reset; seed 8'h00 SHALL be replaced by 8'hA5 so the LFSR is never all-zero.
REQ-021 In DRAW with v>u: if s>=8, reject; else accept iff the post-step LFSR value < (1<<(8-s)).
REQ-022 In DRAW with v<=u, the decision SHALL be accept and the LFSR SHALL still advance.
REQ-023 SHALL register out_p on the DRAW->DONE edge.

Reset
REQ-024 While in_reset=0: state=IDLE, out_busy=0, out_done=0, out_p=0, LFSR=8'h00, seeded flag cleared, statistics counters cleared.
REQ-025 Reset asserted mid-operation SHALL abort the decision with no out_done pulse; the first start after release SHALL reseed from in_seed.

Configuration
REQ-026 Macro MOVE_ACCEPTANCE_STATS_EN defined: SHALL add output ports out_accept_count (16 bits) and out_reject_count (16 bits), which increment on out_done for accept and reject respectively and saturate at 16'hFFFF.
REQ-027 Macro MOVE_ACCEPTANCE_STATS_EN undefined: those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-028 u=3, v=2, any seed, start at edge N -> out_done and out_p=1 at edge N+3; out_busy high for edges N+1 to N+3.
REQ-029 seed=8'h10, SHIFT=1, u=1, v=2 -> LFSR steps to 8'h21 (33) < 128 -> out_p=1.
REQ-030 SHIFT=2, u=2, v=6 (s=8), any seed -> out_p=0.
REQ-031 seed=8'h00, u=0, v=0 -> LFSR seeded to 8'hA5 and stepped to 8'h4A after DRAW; out_p=1.
REQ-032 Pulse in_enable during COMPARE and change in_v during DRAW -> no second decision; the result reflects the values captured at start.
REQ-033 Drop in_reset in DRAW -> out_done stays 0, out_p=0, state=IDLE; with MOVE_ACCEPTANCE_STATS_EN defined, both counters read 0.
